// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, sum, carry, ovf);
    modport slave  (input start, a, b, output busy, done, sum, carry, ovf);
`else
    modport master (output start, a, b, input busy, done, sum, carry);
    modport slave  (input start, a, b, output busy, done, sum, carry);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell, LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] psum_q, psum_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] sum_full;

    assign bit_s    = a_q[0] ^ b_q[0] ^ c_q;
    assign bit_c    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    // The newest bit lands on top; on the last cycle this is the complete sum.
    assign sum_full = {bit_s, psum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    psum_d  = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef SERIAL_ADDER_OVF_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                busy_d = 1'b1;
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                c_d    = bit_c;
                psum_d = sum_full[WIDTH-1:1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = sum_full;
                    carry_d = bit_c;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (bit_s != a_msb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=4); also covers
// back-to-back starts, START during RUN and reset mid-operation.
module tb_serial_adder;
    localparam int WIDTH = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[9];

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [3:0] s, input logic c, input logic o);
        checkOutput({tag, " sum"}, 32'(bus.sum), 32'(s));
        checkOutput({tag, " carry"}, 32'(bus.carry), 32'(c));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput({tag, " ovf"}, 32'(bus.ovf), 32'(o));
`else
        if (o === 1'bx) $display("[TB] unexpected x in ovf expectation for %s", tag);
`endif
    endtask

    // Waits (bounded) for DONE; returns edges seen after the accepting edge.
    task automatic waitDone(output int edges);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 3 * WIDTH) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Presents one operand pair with a single-cycle START and waits for DONE.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, output int edges);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busy after accept", 32'(bus.busy), 32'd1);
        waitDone(edges);
    endtask

    initial begin
        int edges;
        int done_seen;
        n_cmp     = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;

        vecs[0] = '{a: 4'b0100, b: 4'b0010, sum: 4'b0110, carry: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 4'b1001, b: 4'b1001, sum: 4'b0010, carry: 1'b1, ovf: 1'b1};
        vecs[2] = '{a: 4'b0110, b: 4'b0101, sum: 4'b1011, carry: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 4'b1111, b: 4'b0001, sum: 4'b0000, carry: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 4'b0111, b: 4'b0001, sum: 4'b1000, carry: 1'b0, ovf: 1'b1};
        vecs[5] = '{a: 4'b1000, b: 4'b1000, sum: 4'b0000, carry: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 4'b1010, b: 4'b0101, sum: 4'b1111, carry: 1'b0, ovf: 1'b0};
        vecs[7] = '{a: 4'b1111, b: 4'b1111, sum: 4'b1110, carry: 1'b1, ovf: 1'b0};
        vecs[8] = '{a: 4'b0000, b: 4'b0000, sum: 4'b0000, carry: 1'b0, ovf: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkResult("reset", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, edges);
            checkOutput($sformatf("vec%0d latency", i), 32'(edges), 32'(WIDTH));
            checkOutput($sformatf("vec%0d busy at done", i), 32'(bus.busy), 32'd0);
            checkResult($sformatf("vec%0d", i), vecs[i].sum, vecs[i].carry, vecs[i].ovf);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done drops", i), 32'(bus.done), 32'd0);
            checkResult($sformatf("vec%0d hold", i), vecs[i].sum, vecs[i].carry, vecs[i].ovf);
        end

        // Back-to-back: second START issued during the DONE cycle.
        applyStimulus(4'b1111, 4'b0001, edges);
        checkOutput("b2b first latency", 32'(edges), 32'(WIDTH));
        checkResult("b2b first", 4'b0000, 1'b1, 1'b0);
        bus.start = 1'b1;
        bus.a     = 4'b0000;
        bus.b     = 4'b0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("b2b accepted in FIN", 32'(bus.busy), 32'd1);
        checkOutput("b2b done low", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        checkResult("b2b hold mid-run", 4'b0000, 1'b1, 1'b0);
        waitDone(edges);
        checkOutput("b2b second latency", 32'(edges + 1), 32'(WIDTH));
        checkResult("b2b second", 4'b0000, 1'b0, 1'b0);

        // START re-pulsed during RUN must be ignored.
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'b0100;
        bus.b     = 4'b0010;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_seen = 0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 2 || e == 3) begin
                bus.start = 1'b1;
                bus.a     = 4'b1111;
                bus.b     = 4'b1111;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_seen++;
            if (e == WIDTH) checkOutput("ignore done at edge W", 32'(bus.done), 32'd1);
        end
        bus.start = 1'b0;
        checkOutput("ignore done count", 32'(done_seen), 32'd1);
        checkResult("ignore", 4'b0110, 1'b0, 1'b0);

        // Asynchronous reset two edges into RUN aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'b1001;
        bus.b     = 4'b1001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkResult("abort", 4'b0000, 1'b0, 1'b0);
        done_seen = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_seen++;
        end
        checkOutput("abort no done", 32'(done_seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0011, 4'b0001, edges);
        checkOutput("post-reset latency", 32'(edges), 32'(WIDTH));
        checkResult("post-reset", 4'b0100, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
